// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA image window block.
package vga_pkg;

    localparam int unsigned CNT_W = 12;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        MODE_GRAY_LO = 2'd0,
        MODE_GRAY_HI = 2'd1,
        MODE_RGB222  = 2'd2,
        MODE_BARS    = 2'd3
    } pix_mode_e;

    localparam logic [5:0] BORDER_RGB = 6'h3F;

    // Per-pixel side information travelling alongside the RAM read.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       win;
        logic       bord;
        logic [2:0] bar;
    } pix_tag_t;

    localparam pix_tag_t TAG_RST = '{hs: 1'b1, vs: 1'b1, win: 1'b0, bord: 1'b0, bar: 3'd0};

    function automatic logic in_span(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] len);
        return (c >= lo) && (c < lo + len);
    endfunction

    function automatic logic [5:0] pix_colour(input pix_mode_e m,
                                              input logic [7:0] d,
                                              input logic [2:0] bar);
        logic [5:0] c;
        c = '0;
        case (m)
            MODE_GRAY_LO: c = {3{d[1:0]}};
            MODE_GRAY_HI: c = {3{d[7:6]}};
            MODE_RGB222:  c = d[5:0];
            MODE_BARS:    c = {{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}};
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with raw sync, active-area flag and frame-start pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] hcnt_nx_c,
    output logic [CNT_W-1:0] vcnt_nx_c,
    output logic             active_c,
    output logic             hsync_raw_c,
    output logic             vsync_raw_c,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_q + CNT_W'(1);
        end
        // Registered from next-state so the pulse coincides with hcnt==0, vcnt==V_ACTIVE.
        frame_start_d = (hcnt_d == '0) && (vcnt_d == CNT_W'(V_ACTIVE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign hcnt_nx_c   = hcnt_d;
    assign vcnt_nx_c   = vcnt_d;
    assign frame_start = frame_start_q;
    assign active_c    = (hcnt_q < CNT_W'(H_ACTIVE)) && (vcnt_q < CNT_W'(V_ACTIVE));
    assign hsync_raw_c = !((hcnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                           (hcnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw_c = !((vcnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                           (vcnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_image_window.sv
// Places a scaled row-major RAM image inside a VGA raster, with optional border
// and latency-matched sync/colour outputs.
module vga_image_window
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned IMG_W    = 80,
    parameter int unsigned IMG_H    = 80,
    parameter int unsigned SCALE    = 1,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        mode,
    input  logic              border_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic [5:0]        rgb,
    output logic              frame_start
);

    if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
        $error("vga_image_window: SCALE must be in 1..4");
    end
    if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
        $error("vga_image_window: MEM_LAT must be in 1..3");
    end
    if (DATA_W < 8) begin : g_bad_data
        $error("vga_image_window: DATA_W must be at least 8");
    end

    localparam logic [CNT_W-1:0] WIN_W = CNT_W'(IMG_W * SCALE);
    localparam logic [CNT_W-1:0] WIN_H = CNT_W'(IMG_H * SCALE);

    logic [CNT_W-1:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
    logic             active_c, hsync_raw_c, vsync_raw_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hcnt_nx_c   (hcnt_nx),
        .vcnt_nx_c   (vcnt_nx),
        .active_c    (active_c),
        .hsync_raw_c (hsync_raw_c),
        .vsync_raw_c (vsync_raw_c),
        .frame_start (frame_start)
    );

    logic [10:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    pix_mode_e         mode_q, mode_d;
    logic              border_q, border_d;

    // Configuration only changes in vertical blanking so a frame never tears.
    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        base_d   = base_q;
        mode_d   = mode_q;
        border_d = border_q;
        if (frame_start) begin
            pos_x_d  = pos_x;
            pos_y_d  = pos_y;
            base_d   = base_addr;
            mode_d   = pix_mode_e'(mode);
            border_d = border_en;
        end
    end

    logic [CNT_W-1:0] px, py;
    logic             active_nx, win_c, win_nx, bord_c;

    assign px        = CNT_W'(pos_x_q);
    assign py        = CNT_W'(pos_y_q);
    assign active_nx = (hcnt_nx < CNT_W'(H_ACTIVE)) && (vcnt_nx < CNT_W'(V_ACTIVE));
    assign win_c     = active_c && in_span(hcnt, px, WIN_W) && in_span(vcnt, py, WIN_H);
    assign win_nx    = active_nx && in_span(hcnt_nx, px, WIN_W) && in_span(vcnt_nx, py, WIN_H);
    // The +1 offset lets the ring one pixel outside the window be tested without going negative.
    assign bord_c    = border_q && active_c && !win_c &&
                       in_span(hcnt + CNT_W'(1), px, WIN_W + CNT_W'(2)) &&
                       in_span(vcnt + CNT_W'(1), py, WIN_H + CNT_W'(2));

    logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, addr_q, addr_d;
    logic [1:0]        sx_q, sx_d, sy_q, sy_d;

    // Address registers are prepared one cycle early so mem_addr matches the current pixel.
    always_comb begin
        col_d      = col_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (frame_start) begin
            row_base_d = base_addr;
            sy_d       = '0;
        end else if (win_c && !win_nx) begin
            if (sy_q == 2'(SCALE - 1)) begin
                sy_d       = '0;
                row_base_d = row_base_q + ADDR_W'(IMG_W);
            end else begin
                sy_d = sy_q + 2'd1;
            end
        end
        if (win_nx) begin
            if (!win_c) begin
                col_d = '0;
                sx_d  = '0;
            end else if (sx_q == 2'(SCALE - 1)) begin
                col_d = col_q + ADDR_W'(1);
                sx_d  = '0;
            end else begin
                sx_d = sx_q + 2'd1;
            end
            addr_d = row_base_d + col_d;
        end
    end

    pix_tag_t   tag_c;
    pix_tag_t   tag_q [MEM_LAT];
    pix_tag_t   tag_d [MEM_LAT];
    pix_tag_t   tag_out;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;

    always_comb begin
        tag_c.hs   = hsync_raw_c;
        tag_c.vs   = vsync_raw_c;
        tag_c.win  = win_c;
        tag_c.bord = bord_c;
        tag_c.bar  = col_q[2:0];
        tag_d[0]   = tag_c;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out = tag_q[MEM_LAT-1];

    always_comb begin
        hsync_d = tag_out.hs;
        vsync_d = tag_out.vs;
        rgb_d   = '0;
        if (tag_out.win) begin
            rgb_d = pix_colour(mode_q, mem_data[7:0], tag_out.bar);
        end else if (tag_out.bord) begin
            rgb_d = BORDER_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            base_q     <= '0;
            mode_q     <= MODE_GRAY_LO;
            border_q   <= 1'b0;
            col_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                tag_q[i] <= TAG_RST;
            end
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= '0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            base_q     <= base_d;
            mode_q     <= mode_d;
            border_q   <= border_d;
            col_q      <= col_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                tag_q[i] <= tag_d[i];
            end
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
        end
    end

    assign mem_addr = addr_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_image_window.sv
// Randomized bench for vga_image_window on a reduced raster, checked every cycle
// against a pixel-coordinate reference model.
module tb_vga_image_window;

    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6, HT = HA + HFP + HSW + HBP;
    localparam int VA = 30, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int IW = 8, IH = 5, SC = 2, AW = 8, LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   pos_x, pos_y;
    logic [AW-1:0] base_addr;
    logic [1:0]    mode;
    logic          border_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          hsync, vsync, frame_start;
    logic [5:0]    rgb;

    always #5 clk = ~clk;

    vga_image_window #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .IMG_W (IW), .IMG_H (IH), .SCALE (SC),
        .ADDR_W (AW), .DATA_W (8), .MEM_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .base_addr   (base_addr),
        .mode        (mode),
        .border_en   (border_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    // Synchronous RAM with LAT cycles of read latency.
    logic [7:0] ram [256];
    logic [7:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data = rd_pipe[LAT-1];

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } out_t;

    out_t          exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            n;
    int            m_px, m_py, m_base, m_mode, m_bord;
    logic [AW-1:0] exp_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        exp_q.delete();
        repeat (LAT + 1) exp_q.push_back(out_t'{hs: 1'b1, vs: 1'b1, rgb: 6'd0});
        m_px = 0; m_py = 0; m_base = 0; m_mode = 0; m_bord = 0;
        exp_addr = '0;
    endtask

    // One pixel clock: predict pixel n, compare the outputs due now, advance to next negedge.
    task automatic step();
        int         h, v, col, row, addr;
        bit         act, win, brd, fs;
        logic [7:0] d;
        logic [5:0] c;
        out_t       e, o;
        h   = n % HT;
        v   = (n / HT) % VT;
        fs  = (h == 0) && (v == VA);
        act = (h < HA) && (v < VA);
        win = act && h >= m_px && h < m_px + IW * SC && v >= m_py && v < m_py + IH * SC;
        brd = (m_bord != 0) && act && !win && h + 1 >= m_px && h <= m_px + IW * SC
              && v + 1 >= m_py && v <= m_py + IH * SC;
        c = 6'd0;
        if (win) begin
            col  = (h - m_px) / SC;
            row  = (v - m_py) / SC;
            addr = (m_base + row * IW + col) % 256;
            exp_addr = AW'(addr);
            d = ram[addr[7:0]];
            case (m_mode)
                0:       c = {3{d[1:0]}};
                1:       c = {3{d[7:6]}};
                2:       c = d[5:0];
                default: c = {{2{col[2]}}, {2{col[1]}}, {2{col[0]}}};
            endcase
        end else if (brd) begin
            c = 6'h3F;
        end
        e.hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
        e.vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
        e.rgb = c;
        exp_q.push_back(e);
        o = exp_q.pop_front();
        check_eq("hsync", 32'(hsync), 32'(o.hs));
        check_eq("vsync", 32'(vsync), 32'(o.vs));
        check_eq("rgb", 32'(rgb), 32'(o.rgb));
        check_eq("frame_start", 32'(frame_start), 32'(fs));
        check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (fs) begin
            m_px   = int'(pos_x);
            m_py   = int'(pos_y);
            m_base = int'(base_addr);
            m_mode = int'(mode);
            m_bord = int'(border_en);
        end
        n++;
        @(negedge clk);
    endtask

    task automatic junk_inputs();
        pos_x     = 11'($urandom);
        pos_y     = 11'($urandom);
        base_addr = AW'($urandom);
        mode      = 2'($urandom);
        border_en = 1'($urandom);
    endtask

    // Scribble on the inputs mid-frame, then present the config that the next frame_start latches.
    task automatic run_frame(input int px, input int py, input int base, input int md, input int bd);
        junk_inputs();
        repeat (FRAME / 4) step();
        junk_inputs();
        repeat (FRAME / 4) step();
        pos_x     = 11'(px);
        pos_y     = 11'(py);
        base_addr = AW'(base);
        mode      = 2'(md);
        border_en = 1'(bd);
        repeat (FRAME - 2 * (FRAME / 4)) step();
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_hsync"}, 32'(hsync), 32'd1);
        check_eq({pfx, "_vsync"}, 32'(vsync), 32'd1);
        check_eq({pfx, "_rgb"}, 32'(rgb), 32'd0);
        check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        pos_x = '0; pos_y = '0; base_addr = '0; mode = '0; border_en = 1'b0;
        n = 0;

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        model_reset();

        run_frame(0, 0, 0, 0, 0);
        run_frame(30, 25, 5, 2, 1);
        run_frame(10, 4, 250, 2, 0);
        run_frame(12, 8, 0, 3, 1);
        run_frame(2000, 3, 7, 2, 1);
        run_frame(5, 1500, 9, 1, 1);
        run_frame(0, 0, 200, 1, 1);
        run_frame(HA - 1, VA - 1, 50, 2, 1);
        for (int k = 0; k < 4; k++) begin
            run_frame(int'($urandom_range(0, 45)), int'($urandom_range(0, 35)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)));
        end
        run_frame(0, 0, 0, 0, 0);

        repeat (777) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        run_frame(3, 2, 100, 2, 1);
        run_frame(20, 15, 33, 0, 1);
        run_frame(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_image_window.md
Name: vga_image_window

Overview:
Parametrised successor of the fixed 80x80 grayscale VGA window block. Generates VGA timing internally, scans a row-major image from synchronous block RAM, and places it at a runtime-programmable position with integer pixel replication and selectable pixel format. Sits between the frame-buffer RAM and the board's 6-bit RGB DAC pins. Memory-latency compensation keeps sync and colour aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clk cycles
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
IMG_W / IMG_H, 80 / 80, source image size in pixels
SCALE, 1, integer replication factor 1..4, both axes
ADDR_W, 13, memory address width
DATA_W, 8, memory data width, minimum 8
MEM_LAT, 1, RAM read latency in cycles, 1..3

Ports:
clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pos_x  in  11  window left column
pos_y  in  11  window top line
base_addr  in  ADDR_W  image start address, for page flipping
mode  in  2  0=gray from data[1:0], 1=gray from data[7:6], 2=RGB222 data[5:0], 3=colour-bar test
border_en  in  1  draw 1-pixel white border around window
mem_addr  out  ADDR_W  RAM read address
mem_data  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_addr
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
rgb  out  6  {r[1:0],g[1:0],b[1:0]}
frame_start  out  1  one-cycle pulse at first blanking line

Behaviour:
- Reset values: hcnt=vcnt=0, hsync=vsync=1, rgb=0, mem_addr=0, frame_start=0. Latched config is pos 0, base 0, mode 0, border 0.
- Counter hcnt wraps at H_TOTAL-1; at that wrap vcnt increments, and vcnt wraps at V_TOTAL-1. Raw sync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and the vertical equivalent.
- frame_start pulses when hcnt==0 and vcnt==V_ACTIVE. The same cycle latches pos_x, pos_y, base_addr, mode and border_en. Mid-frame input changes never tear the image.
- Window: px in [pos_x, pos_x+IMG_W*SCALE) and py in [pos_y, pos_y+IMG_H*SCALE), intersected with the active area. The overhang is clipped.
- Addressing is incremental, with no multiplier.
  - Column counter col and sub-counter sx advance inside the window. col increments when sx==SCALE-1.
  - The row counter advances after the last window line of each SCALE group.
  - mem_addr = base + row*IMG_W + col, maintained as a row_base register plus col. Add with ADDR_W wrap.
  - Outside the window, mem_addr holds its last value.
- Pipeline: address issued cycle t; data at t+MEM_LAT; rgb registered at t+MEM_LAT+1. hsync, vsync and the in-window/border flags are delayed MEM_LAT+1 cycles to match. frame_start is not delayed.
- Colour mapping:
  - mode0: {g2,g2,g2} with g2=data[1:0].
  - mode1: g2=data[7:6].
  - mode2: data[5:0].
  - mode3: 8 vertical bars by col[2:0] (bit2→R, bit1→G, bit0→B each 2'b11); mem_data ignored.
- border_en: pixels one outside the window perimeter show 6'b111111, inside the active area only. Window pixels take priority.
- rgb=0 in blanking and outside the window/border.
- Edges:
  - pos such that the window starts beyond the active area → entire frame black, address static.
  - SCALE outside 1..4 is a elaboration-time error.
  - Reset asserted mid-line forces outputs to reset values immediately. Scanning resumes at hcnt=0,vcnt=0 after release.

Decomposition:
- Package vga_pkg: timing constants, H_TOTAL/V_TOTAL derivations, mode encodings, and the border colour constant.
- One sub-module, vga_timing: counters plus raw sync/active. It outputs hcnt, vcnt, active, raw hsync/vsync and frame_start.
- Window, address, pipeline and colour logic stay in the top.

Test Plan:
- Reset release, defaults → hsync period 800 cycles with 96-cycle low pulse; vsync period 525 lines with 2-line low; frame_start once per 420000 cycles.
- pos=(280,200), SCALE=1, MEM_LAT=1, mode0, RAM data=addr[7:0] → first window pixel at hcnt 280+2 (rgb delay) shows gray of addr 0. Pixel (col 5,row 3) requests address 245.
- SCALE=2, pos=(0,0) → each address held 2 cycles and each row repeated 2 lines. Row 1 begins on line 2 at address 80.
- pos_x=600 → columns 0..39 displayed; pixel 640+ black. Next row still starts at row_base+80.
- base_addr changed and mode 0→2 mid-frame → no visible change until after frame_start. The next frame uses the new base and RGB222.
- mode3 with border_en, pos=(100,100) → white at px 99 and py 99, colour bars inside; mem_data toggling has no effect on rgb.
